// File: rtl/wb_pipe_reg_if.sv
// rtl/wb_pipe_reg_if.sv - MEM/WB pipeline register bus (WB_MUX_EN adds wb_data_o)
interface wb_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              en_i;
    logic              flush_i;
    logic              valid_i;
    logic [1:0]        WB_i;
    logic [DATA_W-1:0] ReadData_i;
    logic [DATA_W-1:0] ALU_i;
    logic [ADDR_W-1:0] rd_i;
    logic [ADDR_W-1:0] fwd_addr_i;
    logic              valid_o;
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic [DATA_W-1:0] rdata_o;
    logic [DATA_W-1:0] alu_o;
    logic [ADDR_W-1:0] rd_o;
    logic              fwd_hit_o;
    logic [DATA_W-1:0] fwd_data_o;
`ifdef WB_MUX_EN
    logic [DATA_W-1:0] wb_data_o;
`endif

    modport master (
        output en_i, flush_i, valid_i, WB_i, ReadData_i, ALU_i, rd_i, fwd_addr_i,
`ifdef WB_MUX_EN
        input  wb_data_o,
`endif
        input  valid_o, RegWrite_o, MemtoReg_o, rdata_o, alu_o, rd_o,
               fwd_hit_o, fwd_data_o
    );

    modport slave (
        input  en_i, flush_i, valid_i, WB_i, ReadData_i, ALU_i, rd_i, fwd_addr_i,
`ifdef WB_MUX_EN
        output wb_data_o,
`endif
        output valid_o, RegWrite_o, MemtoReg_o, rdata_o, alu_o, rd_o,
               fwd_hit_o, fwd_data_o
    );
endinterface

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - DEPTH-stage MEM/WB pipeline register with forwarding lookup (WB_MUX_EN adds wb_data_o)
module wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_pipe_reg_if.slave bus
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
            $error("wb_pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    // Index 0 is the youngest stage, DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]             v_q;
    logic [DEPTH-1:0][1:0]        wb_q;
    logic [DEPTH-1:0][DATA_W-1:0] rdata_q;
    logic [DEPTH-1:0][DATA_W-1:0] alu_q;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Stage registers: flush kills valids only, enable shifts everything including bubbles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            v_q     <= '0;
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else if (bus.flush_i) begin
            v_q <= '0;
        end else if (bus.en_i) begin
            v_q[0]     <= bus.valid_i;
            wb_q[0]    <= bus.WB_i;
            rdata_q[0] <= bus.ReadData_i;
            alu_q[0]   <= bus.ALU_i;
            rd_q[0]    <= bus.rd_i;
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]     <= v_q[k-1];
                wb_q[k]    <= wb_q[k-1];
                rdata_q[k] <= rdata_q[k-1];
                alu_q[k]   <= alu_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && wb_q[k][0] && (rd_q[k] == bus.fwd_addr_i) &&
                (bus.fwd_addr_i != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_q[k][1] ? rdata_q[k] : alu_q[k];
            end
        end
    end

    assign bus.valid_o    = v_q[DEPTH-1];
    assign bus.RegWrite_o = v_q[DEPTH-1] & wb_q[DEPTH-1][0];
    assign bus.MemtoReg_o = wb_q[DEPTH-1][1];
    assign bus.rdata_o    = rdata_q[DEPTH-1];
    assign bus.alu_o      = alu_q[DEPTH-1];
    assign bus.rd_o       = rd_q[DEPTH-1];
    assign bus.fwd_hit_o  = fwd_hit;
    assign bus.fwd_data_o = fwd_data;

`ifdef WB_MUX_EN
    assign bus.wb_data_o = wb_q[DEPTH-1][1] ? rdata_q[DEPTH-1] : alu_q[DEPTH-1];
`endif

endmodule
